// File: rtl/hyper_pkg.sv
// Shared types and sizes for the DRAM-to-LSAB block mover.
// Provides the FSM state encoding, field widths and the read-latency pipeline entry.
// pair_entry() works out which words of a DRAM column pair belong to the block.
package hyper_pkg;

  localparam int unsigned NUM_SECTIONS = 4;
  localparam int unsigned SEC_W        = $clog2(NUM_SECTIONS);
  localparam int unsigned ADDR_W       = 9;
  localparam int unsigned CNT_W        = 6;
  localparam int unsigned ANCILL_W     = 25;
  localparam int unsigned SEL_W        = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_GAP   = 3'd2,
    ST_STALL = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // One outstanding paired-column read: which halves get written, and
  // whether this pair holds the final word of the block.
  typedef struct packed {
    logic lo;
    logic hi;
    logic last;
  } pipe_entry_t;

  // odd: current word address is the odd half of its pair.
  // left: words still to be requested (non-zero when called from REQ).
  function automatic pipe_entry_t pair_entry(input logic odd, input logic [CNT_W-1:0] left);
    pipe_entry_t e;
    e.lo   = ~odd;
    e.hi   = odd ? (left != '0) : (left > CNT_W'(1));
    e.last = (left == (CNT_W'(e.lo) + CNT_W'(e.hi)));
    return e;
  endfunction

endpackage

// File: rtl/hyper_rdlat_pipe.sv
// Fixed-latency tracker for outstanding DRAM pair reads: a DEPTH-stage shift register.
// Ports: CLK/RST (sync, active-low), push_vld/push_dat in; pop_vld/pop_dat out after DEPTH
// cycles; empty (nothing in flight) and older_vld (something behind the exiting stage).
module hyper_rdlat_pipe
  import hyper_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        push_vld,
  input  pipe_entry_t push_dat,
  output logic        pop_vld,
  output pipe_entry_t pop_dat,
  output logic        empty,
  output logic        older_vld
);

  logic        [DEPTH-1:0] vld_q, vld_d;
  pipe_entry_t [DEPTH-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = {vld_q[DEPTH-2:0], push_vld};
    dat_d = {dat_q[DEPTH-2:0], (push_vld ? push_dat : pipe_entry_t'('0))};
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign pop_vld   = vld_q[DEPTH-1];
  assign pop_dat   = dat_q[DEPTH-1];
  assign empty     = ~|vld_q;
  assign older_vld = |vld_q[DEPTH-2:0];

endmodule

// File: rtl/hyper_mvblck_frdram.sv
// Moves a block of words from a DRAM column range into one of four LSAB sections by issuing
// paired-column MCU reads (at most one every 2 cycles) and timing LSAB write strobes to the
// fixed read latency. Ports: ISSUE/params in, MCU request out, LSAB write controls out,
// COUNT_SENT/ABRUPT_STOP/WORKING status out. Optional macro HYPER_FRDRAM_TIMEOUT_EN adds a
// stall timeout that truncates the block.
module hyper_mvblck_frdram
  import hyper_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 4,
  parameter int unsigned TIMEOUT_W  = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                LSAB_0_AFULL,
  input  logic                LSAB_1_AFULL,
  input  logic                LSAB_2_AFULL,
  input  logic                LSAB_3_AFULL,
  output logic                LSAB_WRITE,
  output logic [SEC_W-1:0]    LSAB_SECTION,
  output logic                LSAB_HALF,
  output logic                LSAB_LAST,
  output logic                LSAB_INT,
  output logic [ANCILL_W-1:0] LSAB_ANCILL,
  input  logic [ADDR_W-1:0]   START_ADDRESS,
  input  logic [CNT_W-1:0]    COUNT_REQ,
  input  logic [SEC_W-1:0]    SECTION,
  input  logic [SEL_W-1:0]    DRAM_SEL,
  input  logic                IRQ_REQ,
  input  logic [ANCILL_W-1:0] ANCILL_IN,
  input  logic                ISSUE,
  output logic [CNT_W-1:0]    COUNT_SENT,
  output logic                ABRUPT_STOP,
  output logic                WORKING,
  output logic [ADDR_W-1:0]   MCU_COLL_ADDRESS,
  output logic [SEL_W-1:0]    MCU_REQUEST_ACCESS
);

  if (RD_LATENCY < 2 || RD_LATENCY > 8 || TIMEOUT_W < 1) begin : g_bad_param
    $error("hyper_mvblck_frdram: RD_LATENCY must be 2..8 and TIMEOUT_W at least 1");
  end

  // Block context
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    left_q, left_d;
  logic [SEC_W-1:0]    section_q, section_d;
  logic                irq_q, irq_d;
  logic [ANCILL_W-1:0] ancill_q, ancill_d;
  logic [SEL_W-1:0]    sel_q, sel_d;

  // MCU request outputs
  logic [SEL_W-1:0]    mcu_req_q, mcu_req_d;
  logic [ADDR_W-1:0]   mcu_addr_q, mcu_addr_d;

  // LSAB write outputs
  logic                wr_q, wr_d;
  logic                half_q, half_d;
  logic                last_q, last_d;
  logic                int_q, int_d;
  logic [ANCILL_W-1:0] ancill_out_q, ancill_out_d;
  logic                hi_pend_q, hi_pend_d;
  logic                hi_last_q, hi_last_d;

  // Status
  logic [CNT_W-1:0]    sent_q, sent_d;
  logic [CNT_W-1:0]    count_sent_q, count_sent_d;
  logic                abrupt_q, abrupt_d;
  logic                busy1_q, busy2_q;

  // Pipeline
  logic                push_vld;
  pipe_entry_t         push_dat;
  logic                pop_vld;
  pipe_entry_t         pop_dat;
  logic                pipe_empty;
  logic                pipe_older;
  logic [CNT_W-1:0]    taken;
  logic                afull_sel;
  logic                force_last;

`ifdef HYPER_FRDRAM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 force_last_q, force_last_d;
  assign force_last = force_last_q;
`else
  assign force_last = 1'b0;
`endif

  hyper_rdlat_pipe #(.DEPTH(RD_LATENCY)) u_pipe (
    .CLK       (CLK),
    .RST       (RST),
    .push_vld  (push_vld),
    .push_dat  (push_dat),
    .pop_vld   (pop_vld),
    .pop_dat   (pop_dat),
    .empty     (pipe_empty),
    .older_vld (pipe_older)
  );

  always_comb begin
    case (section_q)
      2'd0:    afull_sel = LSAB_0_AFULL;
      2'd1:    afull_sel = LSAB_1_AFULL;
      2'd2:    afull_sel = LSAB_2_AFULL;
      default: afull_sel = LSAB_3_AFULL;
    endcase
  end

  // Request side FSM
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    left_d       = left_q;
    section_d    = section_q;
    irq_d        = irq_q;
    ancill_d     = ancill_q;
    sel_d        = sel_q;
    mcu_req_d    = '0;
    mcu_addr_d   = '0;
    push_vld     = 1'b0;
    push_dat     = pair_entry(addr_q[0], left_q);
    taken        = CNT_W'(push_dat.lo) + CNT_W'(push_dat.hi);
    count_sent_d = count_sent_q;
    abrupt_d     = abrupt_q;
`ifdef HYPER_FRDRAM_TIMEOUT_EN
    tmo_d        = '0;
    force_last_d = force_last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ISSUE) begin
          section_d = SECTION;
          addr_d    = START_ADDRESS;
          left_d    = COUNT_REQ;
          irq_d     = IRQ_REQ;
          ancill_d  = ANCILL_IN;
          sel_d     = DRAM_SEL;
`ifdef HYPER_FRDRAM_TIMEOUT_EN
          force_last_d = 1'b0;
`endif
          if (COUNT_REQ != '0) begin
            state_d = ST_REQ;
          end else begin
            count_sent_d = '0;
            abrupt_d     = 1'b0;
          end
        end
      end
      ST_REQ: begin
        if (afull_sel) begin
          state_d = ST_STALL;
        end else begin
          mcu_req_d  = sel_q;
          mcu_addr_d = {addr_q[ADDR_W-1:1], 1'b0};
          push_vld   = 1'b1;
          left_d     = left_q - taken;
          addr_d     = addr_q + ADDR_W'(taken);
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = (left_q == '0) ? ST_DRAIN : ST_REQ;
      end
      ST_STALL: begin
        if (!afull_sel) state_d = ST_REQ;
`ifdef HYPER_FRDRAM_TIMEOUT_EN
        else if (tmo_q == '1) begin
          left_d       = '0;
          state_d      = ST_DRAIN;
          force_last_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_DRAIN: begin
        // hi_pend_q covers the odd word that trails its pair out of the pipe.
        if (pipe_empty && !hi_pend_q) begin
          count_sent_d = sent_q;
          abrupt_d     = force_last;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write side: even word on pipe exit, odd word one cycle later.
  always_comb begin
    wr_d      = 1'b0;
    half_d    = 1'b0;
    last_d    = 1'b0;
    hi_pend_d = pop_vld & pop_dat.hi;
    hi_last_d = pop_dat.last;
    if (pop_vld && pop_dat.lo) begin
      wr_d   = 1'b1;
      half_d = 1'b0;
      // After a timeout the youngest in-flight word closes the block.
      last_d = ~pop_dat.hi & (pop_dat.last | (force_last & ~pipe_older));
    end else if (hi_pend_q) begin
      wr_d   = 1'b1;
      half_d = 1'b1;
      last_d = hi_last_q | (force_last & pipe_empty);
    end
    int_d        = last_d & (irq_q | force_last);
    ancill_out_d = last_d ? ancill_q : '0;
    sent_d       = (state_q == ST_IDLE && ISSUE) ? '0 : sent_q + CNT_W'(wr_d);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      left_q       <= '0;
      section_q    <= '0;
      irq_q        <= 1'b0;
      ancill_q     <= '0;
      sel_q        <= '0;
      mcu_req_q    <= '0;
      mcu_addr_q   <= '0;
      wr_q         <= 1'b0;
      half_q       <= 1'b0;
      last_q       <= 1'b0;
      int_q        <= 1'b0;
      ancill_out_q <= '0;
      hi_pend_q    <= 1'b0;
      hi_last_q    <= 1'b0;
      sent_q       <= '0;
      count_sent_q <= '0;
      abrupt_q     <= 1'b0;
      busy1_q      <= 1'b0;
      busy2_q      <= 1'b0;
`ifdef HYPER_FRDRAM_TIMEOUT_EN
      tmo_q        <= '0;
      force_last_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      left_q       <= left_d;
      section_q    <= section_d;
      irq_q        <= irq_d;
      ancill_q     <= ancill_d;
      sel_q        <= sel_d;
      mcu_req_q    <= mcu_req_d;
      mcu_addr_q   <= mcu_addr_d;
      wr_q         <= wr_d;
      half_q       <= half_d;
      last_q       <= last_d;
      int_q        <= int_d;
      ancill_out_q <= ancill_out_d;
      hi_pend_q    <= hi_pend_d;
      hi_last_q    <= hi_last_d;
      sent_q       <= sent_d;
      count_sent_q <= count_sent_d;
      abrupt_q     <= abrupt_d;
      busy1_q      <= (state_q != ST_IDLE);
      busy2_q      <= busy1_q;
`ifdef HYPER_FRDRAM_TIMEOUT_EN
      tmo_q        <= tmo_d;
      force_last_q <= force_last_d;
`endif
    end
  end

  assign LSAB_WRITE         = wr_q;
  assign LSAB_SECTION       = section_q;
  assign LSAB_HALF          = half_q;
  assign LSAB_LAST          = last_q;
  assign LSAB_INT           = int_q;
  assign LSAB_ANCILL        = ancill_out_q;
  assign COUNT_SENT         = count_sent_q;
  assign ABRUPT_STOP        = abrupt_q;
  assign WORKING            = busy2_q;
  assign MCU_COLL_ADDRESS   = mcu_addr_q;
  assign MCU_REQUEST_ACCESS = mcu_req_q;

endmodule

// File: tb/tb_hyper_mvblck_frdram.sv
module tb_hyper_mvblck_frdram;

  localparam int L = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  afull = 4'b0;
  logic        LSAB_WRITE, LSAB_HALF, LSAB_LAST, LSAB_INT, ABRUPT_STOP, WORKING;
  logic [1:0]  LSAB_SECTION, MCU_REQUEST_ACCESS;
  logic [24:0] LSAB_ANCILL;
  logic [5:0]  COUNT_SENT;
  logic [8:0]  MCU_COLL_ADDRESS;
  logic [8:0]  START_ADDRESS = '0;
  logic [5:0]  COUNT_REQ = '0;
  logic [1:0]  SECTION = '0;
  logic [1:0]  DRAM_SEL = '0;
  logic        IRQ_REQ = 1'b0;
  logic [24:0] ANCILL_IN = '0;
  logic        ISSUE = 1'b0;

  hyper_mvblck_frdram #(.RD_LATENCY(L), .TIMEOUT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .LSAB_0_AFULL(afull[0]), .LSAB_1_AFULL(afull[1]),
    .LSAB_2_AFULL(afull[2]), .LSAB_3_AFULL(afull[3]),
    .LSAB_WRITE(LSAB_WRITE), .LSAB_SECTION(LSAB_SECTION), .LSAB_HALF(LSAB_HALF),
    .LSAB_LAST(LSAB_LAST), .LSAB_INT(LSAB_INT), .LSAB_ANCILL(LSAB_ANCILL),
    .START_ADDRESS(START_ADDRESS), .COUNT_REQ(COUNT_REQ), .SECTION(SECTION),
    .DRAM_SEL(DRAM_SEL), .IRQ_REQ(IRQ_REQ), .ANCILL_IN(ANCILL_IN), .ISSUE(ISSUE),
    .COUNT_SENT(COUNT_SENT), .ABRUPT_STOP(ABRUPT_STOP), .WORKING(WORKING),
    .MCU_COLL_ADDRESS(MCU_COLL_ADDRESS), .MCU_REQUEST_ACCESS(MCU_REQUEST_ACCESS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [8:0] addr;
    logic [1:0] sel;
    bit lo, hi, lo_last, hi_last;
  } req_t;
  typedef struct {
    int   cyc;
    logic half;
    logic last;
  } wr_t;

  req_t req_q[$];
  wr_t  wr_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 0;
  logic [1:0]  cur_sec, cur_sel;
  logic        cur_irq;
  logic [24:0] cur_anc;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {14'd0, LSAB_WRITE, LSAB_SECTION, LSAB_HALF, LSAB_LAST, LSAB_INT, LSAB_ANCILL,
            COUNT_SENT, ABRUPT_STOP, WORKING, MCU_COLL_ADDRESS, MCU_REQUEST_ACCESS};
  endfunction

  // Reference: the block is count consecutive word addresses (mod 512); every run of
  // words sharing one even-aligned pair is one request.
  task automatic build_model(input logic [8:0] start, input int count);
    req_t r;
    bit   have = 0;
    logic [8:0] a;
    for (int k = 0; k < count; k++) begin
      a = start + 9'(k);
      if (k == 0 || a[0] == 1'b0) begin
        if (have) req_q.push_back(r);
        r.addr = {a[8:1], 1'b0};
        r.sel = cur_sel;
        r.lo = 0; r.hi = 0; r.lo_last = 0; r.hi_last = 0;
        have = 1;
      end
      if (a[0] == 1'b0) begin
        r.lo = 1; r.lo_last = (k == count - 1);
      end else begin
        r.hi = 1; r.hi_last = (k == count - 1);
      end
    end
    if (have) req_q.push_back(r);
  endtask

  // Monitor: requests are matched against the model; each accepted request schedules
  // its writes RD_LATENCY (even word) and RD_LATENCY+1 (odd word) cycles later.
  initial begin
    forever begin
      @(posedge CLK); #1;
      cyc++;
      if (mon_en) begin
        if (MCU_REQUEST_ACCESS != 2'b00) begin
          if (req_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_request addr=%0h sel=%0d none expected", MCU_COLL_ADDRESS, MCU_REQUEST_ACCESS);
          end else begin
            req_t r;
            wr_t  w;
            r = req_q.pop_front();
            check("request", {MCU_REQUEST_ACCESS, MCU_COLL_ADDRESS}, {r.sel, r.addr});
            if (r.lo) begin w.cyc = cyc + L; w.half = 0; w.last = r.lo_last; wr_q.push_back(w); end
            if (r.hi) begin w.cyc = cyc + L + 1; w.half = 1; w.last = r.hi_last; wr_q.push_back(w); end
          end
        end
        if (LSAB_WRITE) begin
          if (wr_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_write half=%0d none expected", LSAB_HALF);
          end else begin
            wr_t w;
            w = wr_q.pop_front();
            check("write_cyc_sec_half_last", {cyc, LSAB_SECTION, LSAB_HALF, LSAB_LAST},
                  {w.cyc, cur_sec, w.half, w.last});
            if (w.last) check("last_tag_int_ancill", {LSAB_INT, LSAB_ANCILL}, {cur_irq, cur_anc});
          end
        end
      end
    end
  end

  task automatic run_block(input logic [8:0] start, input int count, input logic [1:0] sec,
                           input logic [1:0] sel, input logic irq, input logic [24:0] anc,
                           input int stall_cycles, input bit poke_issue);
    int t;
    int nreq;
    bit seen;
    cur_sec = sec; cur_sel = sel; cur_irq = irq; cur_anc = anc;
    build_model(start, count);
    @(negedge CLK);
    START_ADDRESS = start; COUNT_REQ = 6'(count); SECTION = sec; DRAM_SEL = sel;
    IRQ_REQ = irq; ANCILL_IN = anc; ISSUE = 1'b1;
    afull = 4'($urandom) & ~(4'b0001 << sec);
    @(negedge CLK);
    ISSUE = 1'b0;
    if (poke_issue) begin
      repeat (3) @(negedge CLK);
      START_ADDRESS = ~start; COUNT_REQ = 6'd5; SECTION = sec + 2'd1; ISSUE = 1'b1;
      @(negedge CLK);
      ISSUE = 1'b0;
    end
    if (stall_cycles > 0) begin
      t = 0; seen = 0;
      while (!seen && t < 50) begin
        @(posedge CLK); #2;
        if (MCU_REQUEST_ACCESS != 2'b00) seen = 1;
        t++;
      end
      check("stall_first_req_seen", 64'(seen), 64'd1);
      afull[sec] = 1'b1;
      nreq = 0;
      repeat (stall_cycles) begin
        @(posedge CLK); #2;
        if (MCU_REQUEST_ACCESS != 2'b00) nreq++;
      end
      check("no_req_during_stall", 64'(nreq), 64'd0);
      afull[sec] = 1'b0;
    end
    t = 0;
    while (WORKING !== 1'b1 && t < 50) begin @(posedge CLK); #2; t++; end
    t = 0;
    while (WORKING !== 1'b0 && t < 3000) begin @(posedge CLK); #2; t++; end
    check("block_done_in_time", 64'(t < 3000), 64'd1);
    check("count_sent", 64'(COUNT_SENT), 64'(count));
    check("abrupt_stop", 64'(ABRUPT_STOP), 64'd0);
    check("scoreboard_drained", 64'(req_q.size() + wr_q.size()), 64'd0);
    req_q.delete();
    wr_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    int t;
    repeat (3) @(posedge CLK);
    #2;
    check("reset_outputs", all_outs(), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    mon_en = 1;
    repeat (2) @(negedge CLK);

    run_block(9'h010, 6, 2'd2, 2'd1, 1'b1, 25'h1ABCDEF, 0, 0);
    run_block(9'h011, 3, 2'd1, 2'd2, 1'b0, 25'h0000123, 0, 0);
    run_block(9'h1FE, 4, 2'd3, 2'd3, 1'b1, 25'h1555555, 0, 0);
    run_block(9'h020, 8, 2'd0, 2'd1, 1'b1, 25'h0F0F0F0, 10, 0);
    run_block(9'h100, 10, 2'd1, 2'd2, 1'b0, 25'h0AAAAAA, 0, 1);
    run_block(9'h1FF, 1, 2'd2, 2'd1, 1'b1, 25'h0000001, 0, 0);
    run_block(9'h0A0, 1, 2'd0, 2'd3, 1'b1, 25'h1000000, 0, 0);

    // COUNT_REQ = 0: nothing happens, COUNT_SENT returns to 0.
    @(negedge CLK);
    COUNT_REQ = 6'd0; START_ADDRESS = 9'h033; ISSUE = 1'b1;
    @(negedge CLK);
    ISSUE = 1'b0;
    nw = 0;
    repeat (8) begin @(posedge CLK); #2; if (WORKING) nw++; end
    check("zero_count_working", 64'(nw), 64'd0);
    check("zero_count_sent", 64'(COUNT_SENT), 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_block(9'($urandom_range(0, 511)), $urandom_range(1, 63), 2'($urandom_range(0, 3)),
                2'($urandom_range(1, 3)), 1'($urandom), 25'($urandom),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0, 0);
    end

    // Reset in the middle of a long block.
    cur_sec = 2'd3; cur_sel = 2'd2; cur_irq = 1'b1; cur_anc = 25'h0123456;
    build_model(9'h040, 40);
    @(negedge CLK);
    START_ADDRESS = 9'h040; COUNT_REQ = 6'd40; SECTION = 2'd3; DRAM_SEL = 2'd2;
    IRQ_REQ = 1'b1; ANCILL_IN = 25'h0123456; ISSUE = 1'b1;
    afull = 4'b0;
    @(negedge CLK);
    ISSUE = 1'b0;
    t = 0; nw = 0;
    while (nw < 2 && t < 50) begin
      @(posedge CLK); #2;
      if (MCU_REQUEST_ACCESS != 2'b00) nw++;
      t++;
    end
    check("midreset_two_requests_seen", 64'(nw), 64'd2);
    mon_en = 0;
    RST = 1'b0;
    @(posedge CLK); #2;
    check("midreset_outputs_zero", all_outs(), 64'd0);
    req_q.delete();
    wr_q.delete();
    @(negedge CLK);
    RST = 1'b1;
    nw = 0;
    repeat (20) begin @(posedge CLK); #2; if (LSAB_WRITE) nw++; end
    check("midreset_no_writes_after", 64'(nw), 64'd0);
    check("midreset_idle_after", all_outs(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
